// File: rtl/gray_code_unit_if.sv
// rtl/gray_code_unit_if.sv - stream bundle for the Gray-code engine
//
// Groups the valid/ready request/result signals of gray_code_unit.
//   mode      [1:0]       operation select (00 b2g, 01 g2b, 10 up, 11 down)
//   cnt_load              counter modes: load din instead of stepping
//   in_valid / in_ready   input handshake
//   din       [WIDTH-1:0] input operand
//   out_valid / out_ready result handshake
//   dout      [WIDTH-1:0] registered result
//   wrap                  counter wrapped on this result
//   step_err              sticky Gray-step error (GRAY_STEP_CHECK_EN only)
// Modports: master drives requests and consumes results; slave is the engine.

interface gray_code_unit_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             cnt_load;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             wrap;
`ifdef GRAY_STEP_CHECK_EN
    logic             step_err;
`endif

    modport master (
        output mode, cnt_load, in_valid, din, out_ready,
`ifdef GRAY_STEP_CHECK_EN
        input  step_err,
`endif
        input  in_ready, out_valid, dout, wrap
    );

    modport slave (
        input  mode, cnt_load, in_valid, din, out_ready,
`ifdef GRAY_STEP_CHECK_EN
        output step_err,
`endif
        output in_ready, out_valid, dout, wrap
    );
endinterface

// File: rtl/gray_code_unit.sv
// rtl/gray_code_unit.sv - parametrised Gray-code engine with registered output
//
// Binary->Gray, Gray->binary and an up/down Gray counter behind one
// valid/ready stream, with a single-entry registered output buffer.
// Optional feature macro: GRAY_STEP_CHECK_EN (adds sticky step_err that flags
// consecutive mode-01 inputs differing in other than exactly one bit).
//
// Ports:
//   clk   in   clock, all state updates on rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of gray_code_unit_if (WIDTH must match this module)
// Parameters:
//   WIDTH     data width, >= 2
//   CNT_INIT  binary counter value loaded on reset

module gray_code_unit #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] CNT_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    gray_code_unit_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] dout_r;
    logic             out_valid_r;
    logic             wrap_r;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] res;
    logic             res_wrap;
    logic [WIDTH-1:0] cnt_next;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down: each binary bit is the parity of all
    // Gray bits at and above it.
    function automatic logic [WIDTH-1:0] from_gray(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // The buffer can take a new result whenever it is empty or being drained.
    assign bus.in_ready = !out_valid_r || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = out_valid_r && bus.out_ready;

    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.wrap      = wrap_r;

    // Result and counter update for the transaction presented this cycle;
    // only committed when it is accepted.
    always_comb begin
        res      = '0;
        res_wrap = 1'b0;
        cnt_next = cnt;
        case (bus.mode)
            2'b00: res = to_gray(bus.din);
            2'b01: res = from_gray(bus.din);
            default: begin
                if (bus.cnt_load) begin
                    res      = to_gray(bus.din);
                    cnt_next = bus.din;
                end else begin
                    // Output reflects the count before the step.
                    res = to_gray(cnt);
                    if (!bus.mode[0]) begin
                        res_wrap = &cnt;
                        cnt_next = cnt + ONE;
                    end else begin
                        res_wrap = ~|cnt;
                        cnt_next = cnt - ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= CNT_INIT;
            dout_r      <= '0;
            out_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
        end else if (accept) begin
            cnt         <= cnt_next;
            dout_r      <= res;
            wrap_r      <= res_wrap;
            out_valid_r <= 1'b1;
        end else if (consume) begin
            // dout/wrap keep their last value once drained.
            out_valid_r <= 1'b0;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] last_g;
    logic             have_last;
    logic             step_err_r;
    logic             g2b_accept;

    assign g2b_accept   = accept && (bus.mode == 2'b01);
    assign bus.step_err = step_err_r;

    // Tracks only Gray->binary inputs; any non-unit Hamming step between
    // consecutive ones latches the error until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_g     <= '0;
            have_last  <= 1'b0;
            step_err_r <= 1'b0;
        end else if (g2b_accept) begin
            if (have_last && ($countones(bus.din ^ last_g) != 1)) begin
                step_err_r <= 1'b1;
            end
            last_g    <= bus.din;
            have_last <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_code_unit.sv
// tb/tb_gray_code_unit.sv - directed self-checking bench for gray_code_unit

module tb_gray_code_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    gray_code_unit_if #(.WIDTH(4)) bus ();

    gray_code_unit #(.WIDTH(4), .CNT_INIT(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction and advance one edge; in_valid stays high so
    // consecutive calls stream back to back.
    task automatic xfer(input logic [1:0] m, input logic ld, input logic [3:0] d);
        bus.mode     = m;
        bus.cnt_load = ld;
        bus.din      = d;
        bus.in_valid = 1'b1;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic w);
        chk({tag, ".out_valid"}, bus.out_valid, 1'b1);
        chk({tag, ".dout"}, bus.dout, d);
        chk({tag, ".wrap"}, bus.wrap, w);
    endtask

    initial begin
        bus.mode      = 2'b00;
        bus.cnt_load  = 1'b0;
        bus.din       = 4'b0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.dout", bus.dout, 4'b0000);
        chk("rst.wrap", bus.wrap, 1'b0);
        chk("rst.in_ready", bus.in_ready, 1'b1);
`ifdef GRAY_STEP_CHECK_EN
        chk("rst.step_err", bus.step_err, 1'b0);
`endif
        rst = 1'b0;
        tick();

        // binary -> Gray stream
        xfer(2'b00, 1'b0, 4'b0011); chk_out("b2g0", 4'b0010, 1'b0);
        xfer(2'b00, 1'b0, 4'b1001); chk_out("b2g1", 4'b1101, 1'b0);
        xfer(2'b00, 1'b0, 4'b1110); chk_out("b2g2", 4'b1001, 1'b0);
        xfer(2'b00, 1'b0, 4'b0000); chk_out("b2g3", 4'b0000, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("drain.out_valid", bus.out_valid, 1'b0);

        // Gray -> binary
        xfer(2'b01, 1'b0, 4'b1101); chk_out("g2b0", 4'b1001, 1'b0);
        xfer(2'b01, 1'b0, 4'b1000); chk_out("g2b1", 4'b1111, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("drain2.out_valid", bus.out_valid, 1'b0);
        chk("drain2.dout_hold", bus.dout, 4'b1111);

        // counter: load, up across wrap, down across wrap
        xfer(2'b10, 1'b1, 4'b1110); chk_out("load", 4'b1001, 1'b0);
        xfer(2'b10, 1'b0, 4'b0000); chk_out("up0", 4'b1001, 1'b0);
        xfer(2'b10, 1'b0, 4'b0000); chk_out("up1", 4'b1000, 1'b1);
        xfer(2'b10, 1'b0, 4'b0000); chk_out("up2", 4'b0000, 1'b0);
        xfer(2'b11, 1'b0, 4'b0000); chk_out("dn0", 4'b0001, 1'b0);
        xfer(2'b11, 1'b0, 4'b0000); chk_out("dn1", 4'b0000, 1'b1);
        // cnt is now 1111

        // backpressure: result held, new requests ignored
        bus.out_ready = 1'b0;
        bus.mode      = 2'b10;
        bus.cnt_load  = 1'b1;
        bus.din       = 4'b0110;
        bus.in_valid  = 1'b1;
        #1;
        chk("bp.in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp.hold", 4'b0000, 1'b1);
            chk("bp.in_ready_hold", bus.in_ready, 1'b0);
        end
        bus.mode      = 2'b00;
        bus.cnt_load  = 1'b0;
        bus.din       = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", bus.in_ready, 1'b1);
        tick();
        chk_out("bp.accept", 4'b1000, 1'b0);
        // ignored load must not have touched cnt (still 1111)
        xfer(2'b10, 1'b0, 4'b0000); chk_out("bp.cnt_kept", 4'b1000, 1'b1);

        // reset mid-operation with cnt=5 and a held result
        xfer(2'b10, 1'b1, 4'b0101); chk_out("ld5", 4'b0111, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        tick();
        chk_out("ld5.hold", 4'b0111, 1'b0);
        rst          = 1'b1;
        bus.mode     = 2'b10;
        bus.cnt_load = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        chk("mid_rst.out_valid", bus.out_valid, 1'b0);
        chk("mid_rst.dout", bus.dout, 4'b0000);
        chk("mid_rst.wrap", bus.wrap, 1'b0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        xfer(2'b10, 1'b0, 4'b0000); chk_out("post_rst0", 4'b0000, 1'b0);
        xfer(2'b10, 1'b0, 4'b0000); chk_out("post_rst1", 4'b0001, 1'b0);
        bus.in_valid = 1'b0;
        tick();

`ifdef GRAY_STEP_CHECK_EN
        xfer(2'b01, 1'b0, 4'b0000); chk("se0", bus.step_err, 1'b0);
        xfer(2'b01, 1'b0, 4'b0001); chk("se1", bus.step_err, 1'b0);
        xfer(2'b01, 1'b0, 4'b0011); chk("se2", bus.step_err, 1'b0);
        xfer(2'b01, 1'b0, 4'b0010); chk("se3", bus.step_err, 1'b0);
        xfer(2'b01, 1'b0, 4'b0111); chk("se4", bus.step_err, 1'b1);
        xfer(2'b00, 1'b0, 4'b0110); chk("se_sticky0", bus.step_err, 1'b1);
        xfer(2'b01, 1'b0, 4'b0110); chk("se_sticky1", bus.step_err, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("se_rst", bus.step_err, 1'b0);
        rst = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gray_code_unit.md
Name: gray_code_unit

Overview:
Parametrised Gray-code engine and successor to the fixed 4-bit combinational binary-to-Gray converter.
- Supports binary-to-Gray conversion, Gray-to-binary conversion, and an internal up/down Gray counter, all behind one valid/ready stream interface.
- Output is registered, with a single-entry buffer and backpressure.
- Used in the ALU datapath and as a source of Gray pointers for clock-crossing blocks.

Parameters:
- WIDTH, 4, data width in bits; legal values are 2 or more.
- CNT_INIT, 0, binary value loaded into the internal counter on reset; must fit in WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  operation: 00 bin->gray, 01 gray->bin, 10 count up, 11 count down.
- cnt_load  in  1  counter modes only: load din instead of stepping.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- din  in  WIDTH  input operand.
- out_valid  out  1  dout/wrap hold a valid result.
- out_ready  in  1  downstream accepts the result this cycle.
- dout  out  WIDTH  registered result.
- wrap  out  1  registered flag, qualified by out_valid: counter wrapped on this result.
- step_err  out  1  sticky Gray-step error; present only with GRAY_STEP_CHECK_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, dout=0, wrap=0, step_err=0.
  - Internal counter cnt=CNT_INIT; step-check history cleared.
  - Any held output is discarded; rst overrides all other inputs.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational, no other dependency.
  - Accept occurs when in_valid && in_ready. mode, cnt_load and din are sampled only on accept.
  - Latency is 1 cycle: the result appears in dout with out_valid=1 on the edge after accept.
  - A result is consumed when out_valid && out_ready. Consume and a new accept in the same cycle give back-to-back throughput of 1 per cycle.
  - While out_valid=1 and out_ready=0, dout, wrap and out_valid hold stable.
  - If a result is consumed with no accept, out_valid goes to 0 and dout/wrap keep their old values.
- mode 00: dout = din ^ (din >> 1); wrap=0; cnt unchanged.
- mode 01: dout[WIDTH-1] = din[WIDTH-1], and dout[i] = dout[i+1] ^ din[i] for i = WIDTH-2 down to 0; wrap=0; cnt unchanged.
- mode 10/11 with cnt_load=1: dout = gray(din), cnt <= din, wrap=0.
- mode 10 with cnt_load=0: dout = gray(cnt); wrap = (cnt == all-ones); cnt <= cnt+1 mod 2^WIDTH.
- mode 11 with cnt_load=0: dout = gray(cnt); wrap = (cnt == 0); cnt <= cnt-1 mod 2^WIDTH.
- Counter mechanics:
  - cnt is held in binary and changes only on accepted counter-mode transactions.
  - Conversion modes do not disturb cnt.
  - Switching mode between transactions is legal; there is no state machine beyond the output buffer and cnt.
- Arithmetic: all operations are WIDTH-bit unsigned and wrap modulo 2^WIDTH. No sign handling.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- When defined:
  - Port step_err exists, along with a WIDTH-bit register last_g and flag have_last, both cleared by reset.
  - On each accepted mode-01 transaction with have_last=1, popcount(din ^ last_g) != 1 sets step_err=1.
  - step_err is sticky until rst.
  - Every accepted mode-01 transaction then sets last_g <= din and have_last <= 1. Other modes leave both untouched.
- When not defined: step_err, last_g and have_last do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=4, mode 00, stream din=0011,1001,1110,0000 with out_ready=1 -> dout=0010,1101,1001,0000 one cycle after each accept; out_valid continuous; wrap=0.
- WIDTH=4, mode 01, din=1101 then 1000 -> dout=1001 then 1111.
- WIDTH=4, mode 10:
  - load din=1110 -> dout=1001, wrap=0.
  - Then three steps -> dout=1001 (wrap=0), 1000 (wrap=1), 0000 (wrap=0).
  - Then mode 11 step -> dout=0001, wrap=0 (cnt was 1); next mode 11 step -> dout=0000, wrap=1.
- Backpressure:
  - With a result held, out_ready=0 for 3 cycles -> in_ready=0, dout/out_valid stable, and in_valid inputs are ignored.
  - Raising out_ready with in_valid=1 -> consume and accept in the same cycle.
- Reset mid-operation: out_valid=1 held and cnt=5, then rst pulse -> out_valid=0, dout=0, and the next mode-10 step outputs gray(CNT_INIT).
- GRAY_STEP_CHECK_EN:
  - mode 01 stream 0000,0001,0011,0010 -> step_err stays 0.
  - Next din=0111 -> step_err=1 one cycle after accept, staying 1 until rst.
